// File: rtl/gpio_in_capture.sv
// rtl/gpio_in_capture.sv - synchronised, debounced GPIO input capture with edge flags and irq
module gpio_in_capture #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [1:0]       sel,
    input  logic             re,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1;
    logic [WIDTH-1:0]            sync2;
    logic [WIDTH-1:0]            level;
    logic [WIDTH-1:0]            level_nxt;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]            rise;
    logic [WIDTH-1:0]            fall;
    logic [WIDTH-1:0]            mask;
    logic [WIDTH-1:0]            rise_set;
    logic [WIDTH-1:0]            fall_set;
    logic [WIDTH-1:0]            rise_clr;
    logic [WIDTH-1:0]            fall_clr;
    logic [WIDTH-1:0]            rd_mux;

    // Per-bit debounce: level only follows sync2 after CNT_MAX+1 consecutive mismatches.
    always_comb begin
        level_nxt = level;
        cnt_nxt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] != level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    level_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise_set = level_nxt & ~level;
    assign fall_set = ~level_nxt & level;

    // Read-clear takes the pre-clear flag value; write-1-to-clear uses wdata. Both may act together.
    assign rise_clr = ({WIDTH{re && (sel == 2'd1)}} & rise) | ({WIDTH{we && (sel == 2'd1)}} & wdata);
    assign fall_clr = ({WIDTH{re && (sel == 2'd2)}} & fall) | ({WIDTH{we && (sel == 2'd2)}} & wdata);

    always_comb begin
        rd_mux = level;
        case (sel)
            2'd0:    rd_mux = level;
            2'd1:    rd_mux = rise;
            2'd2:    rd_mux = fall;
            default: rd_mux = mask;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            level  <= '0;
            cnt    <= '0;
            rise   <= '0;
            fall   <= '0;
            mask   <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            sync1  <= pin_in;
            sync2  <= sync1;
            level  <= level_nxt;
            cnt    <= cnt_nxt;
            // A new edge wins over a clear on the same cycle.
            rise   <= (rise & ~rise_clr) | rise_set;
            fall   <= (fall & ~fall_clr) | fall_set;
            if (we && (sel == 2'd3)) begin
                mask <= wdata;
            end
            rvalid <= re;
            if (re) begin
                rdata <= rd_mux;
            end
        end
    end

    assign irq = |((rise | fall) & mask);

endmodule

// File: doc/gpio_in_capture.md
Name: gpio_in_capture

Overview:
- Input-direction counterpart to the core's GPIO output register: samples the 8 external input pins, synchronises and debounces them, and detects rising/falling edges.
- Holds sticky edge flags and an interrupt mask, and presents level/flag/mask data to the CPU through a registered read port.
- Drives a level interrupt toward the core.
- Sits between the chip's ui_in pins and the CPU data bus, beside the output GPIO register.

Parameters:
- WIDTH, 8, number of input pins captured.
- DEBOUNCE_CYCLES, 4, consecutive synchronised-mismatch cycles required before the debounced level changes (legal range 1..255).
- CNT_W, 8, width of each per-bit debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pin_in  input  WIDTH  raw asynchronous pins (from ui_in).
- sel  input  2  register select: 0 = level, 1 = rise flags, 2 = fall flags, 3 = irq mask.
- re  input  1  read strobe, one cycle.
- we  input  1  write strobe, one cycle.
- wdata  input  WIDTH  write data.
- rdata  output  WIDTH  registered read data.
- rvalid  output  1  one-cycle pulse marking rdata valid.
- irq  output  1  interrupt, level, active-high.

Behaviour:
- Reset (async assert, synchronous release): sync flops, debounced level, all counters, rise/fall flags, mask, rdata and rvalid all go to 0. irq = 0.
- Reset mid-operation discards in-flight debounce counts and pending flags immediately.
- Synchroniser: two flops per bit. The synced value lags pin_in by 2 clocks.
- Debounce, per bit, independent:
  - If synced == level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: level <= synced, counter <= 0.
  - Else: counter <= counter+1.
  - Level therefore changes DEBOUNCE_CYCLES edges after synced first differs; pin-to-level latency = 2 + DEBOUNCE_CYCLES cycles.
  - Pulses or glitches shorter than DEBOUNCE_CYCLES synced cycles never change level. Counter restarts on any return to match.
- Edge flags: rise[i] is set on the same edge where level[i] goes 0->1; fall[i] on 1->0. Flags are sticky.
- Flag clearing:
  - Read with sel=1 (or 2) clears the flags returned, on the read edge.
  - Write with sel=1 (or 2) is write-1-to-clear using wdata.
  - A new edge on the same cycle as a clear: set wins, the flag stays 1.
- Mask: written by we with sel=3 (mask <= wdata). Writes with sel=0 are ignored.
- irq = |((rise | fall) & mask), from registers only (no combinational path from inputs).
  - Unmasking an already-set flag raises irq on the next cycle.
- Read:
  - re at edge N: rdata <= selected register (pre-clear value), rvalid = 1 during cycle N+1.
  - Otherwise rvalid = 0 and rdata holds its last value.
- re and we on the same cycle: both act. rdata returns the pre-write value. Clears from read and write are OR'd; set still wins.
- Pins high at reset release: level rises after 2 + DEBOUNCE_CYCLES cycles and sets the corresponding rise flags. Software clears these after boot.
- Back-to-back reads every cycle are supported; each produces an rvalid pulse.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then pin_in 0x00->0x05 held:
   - Level reads 0x05 starting 6 cycles after the change.
   - Rise flags = 0x05, fall = 0x00.
   - Read sel=1 returns 0x05 with rvalid one cycle after re; a second read returns 0x00.
2. Glitch rejection: pin_in bit3 high for 3 cycles, then low:
   - Level, rise and fall all remain 0.
   - A 4-cycle pulse sets rise[3], then fall[3] after it returns low.
3. Interrupt masking:
   - Fall flag 0x80 set with mask=0x00: irq=0.
   - Write sel=3 wdata=0x80: irq=1 next cycle.
   - Write sel=2 wdata=0x80 (W1C): irq=0 next cycle.
4. Set-vs-clear collision: schedule read of sel=1 on the exact edge rise[0] is set:
   - rdata excludes bit0, rise[0] remains 1, and irq stays asserted if mask[0]=1.
5. Async reset mid-debounce: assert rst_n=0 with counter at 2 and flags 0xFF:
   - All outputs are 0 immediately, without waiting for a clock.
   - After release with pins held 0x00, no flags are set.
6. Simultaneous re sel=3 and we sel=3 wdata=0x3C with old mask 0xA5:
   - rdata=0xA5.
   - Subsequent read returns 0x3C.
